vfu_cmd_sched: RTL

- Command sequencer in front of the N-lane FP16 vector functional unit (VFU).
- Accepts one command at a time: opcode plus a vector count. Streams operand pairs into the VFU and holds the VFU opcode stable for the whole command.
- Captures VFU results into a result FIFO. The VFU cannot stall, so a credit scheme guarantees the FIFO never overflows.
- Presents results on a valid/ready stream with a last marker and a completion pulse.

---
 rtl/vfu_cmd_sched.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/vfu_cmd_sched.sv
// rtl/vfu_cmd_sched.sv - command sequencer and result buffer in front of the N-lane FP16 VFU
//
// Accepts one command (opcode + vector count), issues operand pairs to the VFU,
// buffers the VFU results in a credit-protected FIFO and streams them out.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cmd_valid/cmd_ready            command handshake (ready only in IDLE)
//   cmd_inst, cmd_len              opcode and number of vector pairs
//   op_valid/op_ready, op_a, op_b  operand pair stream
//   vfu_vect_A/B, vfu_INST         registered operands and held opcode to the VFU
//   vfu_in_valid                   one-cycle issue strobe to the VFU
//   vfu_out_flat, vfu_out_tvalid   VFU result return (cannot stall)
//   res_valid/res_ready            result stream, res_data head, res_last marker
//   busy, done                     activity flag and one-cycle completion pulse
//   err_unexpected                 sticky flag for results with no credit/space
module vfu_cmd_sched #(
  parameter int N         = 4,
  parameter int LEN_W     = 8,
  parameter int RES_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_inst,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [N*16-1:0]   op_a,
  input  logic [N*16-1:0]   op_b,
  output logic [N*16-1:0]   vfu_vect_A,
  output logic [N*16-1:0]   vfu_vect_B,
  output logic [1:0]        vfu_INST,
  output logic              vfu_in_valid,
  input  logic [N*16-1:0]   vfu_out_flat,
  input  logic              vfu_out_tvalid,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N*16-1:0]   res_data,
  output logic              res_last,
  output logic              busy,
  output logic              done,
  output logic              err_unexpected
);

  localparam int DW    = N * 16;
  localparam int PTR_W = $clog2(RES_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_t;

  state_t state, state_nxt;

  logic [LEN_W-1:0] len, issued, popped, push_idx;
  logic [CNT_W-1:0] inflight, fifo_count;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [DW-1:0]    mem_data [RES_DEPTH];
  logic [RES_DEPTH-1:0] mem_last;

  logic cmd_fire, op_fire, res_accept, push, pop, fifo_full, credit_ok;

  assign cmd_ready  = (state == S_IDLE);
  assign cmd_fire   = cmd_valid && cmd_ready;

  // Credits: every issued-but-unreturned result plus every buffered result
  // must fit in the FIFO, because the VFU cannot be stalled on return.
  assign credit_ok  = ({1'b0, inflight} + {1'b0, fifo_count}) < (CNT_W + 1)'(RES_DEPTH);
  assign op_ready   = (state == S_ISSUE) && credit_ok;
  assign op_fire    = op_valid && op_ready;

  assign fifo_full  = (fifo_count == CNT_W'(RES_DEPTH));
  assign res_accept = vfu_out_tvalid && (inflight != '0);
  // A full-FIFO push can only happen if the credit rule is broken; drop it.
  assign push       = res_accept && !fifo_full;

  assign res_valid  = (fifo_count != '0);
  assign pop        = res_valid && res_ready;
  assign res_data   = res_valid ? mem_data[rd_ptr] : '0;
  assign res_last   = res_valid && mem_last[rd_ptr];

  assign busy       = (state != S_IDLE);
  assign done       = (state == S_FIN);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cmd_fire) state_nxt = (cmd_len == '0) ? S_FIN : S_ISSUE;
      S_ISSUE: if (op_fire && (issued + LEN_W'(1) == len)) state_nxt = S_DRAIN;
      S_DRAIN: if (popped == len) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      len            <= '0;
      issued         <= '0;
      popped         <= '0;
      push_idx       <= '0;
      inflight       <= '0;
      fifo_count     <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      mem_last       <= '0;
      vfu_vect_A     <= '0;
      vfu_vect_B     <= '0;
      vfu_INST       <= '0;
      vfu_in_valid   <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      state        <= state_nxt;
      vfu_in_valid <= op_fire;

      if (cmd_fire) begin
        vfu_INST <= cmd_inst;
        len      <= cmd_len;
        issued   <= '0;
        popped   <= '0;
        push_idx <= '0;
      end else begin
        if (op_fire) issued <= issued + LEN_W'(1);
        if (pop)     popped <= popped + LEN_W'(1);
        if (push)    push_idx <= push_idx + LEN_W'(1);
      end

      if (op_fire) begin
        vfu_vect_A <= op_a;
        vfu_vect_B <= op_b;
      end

      // Simultaneous issue and return leave the in-flight count unchanged.
      case ({op_fire, res_accept})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase

      if (push) begin
        mem_data[wr_ptr] <= vfu_out_flat;
        mem_last[wr_ptr] <= (push_idx == len - LEN_W'(1));
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase

      if (vfu_out_tvalid && ((inflight == '0) || fifo_full)) err_unexpected <= 1'b1;
    end
  end

endmodule
